// File: rtl/booth_mult_seq_pkg.sv
// Shared constants and FSM encoding for the sequential radix-4 Booth multiplier.
package booth_mult_seq_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ITERS  = 16;
    localparam int unsigned ACC_W  = DATA_W + 2;
    localparam int unsigned CNT_W  = $clog2(ITERS + 1);
    localparam int unsigned SHR_W  = ACC_W + DATA_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/booth_mult_seq_recoder.sv
// Radix-4 Booth digit selection: maps a 3-bit window to 0, +/-M or +/-2M at accumulator width.
module booth_recoder
    import booth_mult_seq_pkg::*;
(
    input  logic [2:0]        window,
    input  logic [DATA_W-1:0] m,
    output logic [ACC_W-1:0]  addend_c
);

    logic [ACC_W-1:0] m1;
    logic [ACC_W-1:0] m2;
    logic [ACC_W-1:0] neg1;
    logic [ACC_W-1:0] neg2;

    // Two guard bits keep 2M and -2M exact even for M = -2^31.
    assign m1   = {{2{m[DATA_W-1]}}, m};
    assign m2   = {m1[ACC_W-2:0], 1'b0};
    assign neg1 = (~m1) + ACC_W'(1);
    assign neg2 = (~m2) + ACC_W'(1);

    always_comb begin
        addend_c = '0;
        case (window)
            3'b001, 3'b010: addend_c = m1;
            3'b011:         addend_c = m2;
            3'b100:         addend_c = neg2;
            3'b101, 3'b110: addend_c = neg1;
            default:        addend_c = '0;
        endcase
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential signed 32x32 multiplier, two bits of multiplier retired per RUN cycle.
module booth_mult_seq
    import booth_mult_seq_pkg::*;
(
    input  logic              clk,
    input  logic              Clear,
    input  logic              start,
    input  logic [DATA_W-1:0] multiplicand,
    input  logic [DATA_W-1:0] multiplier,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product_hi,
    output logic [DATA_W-1:0] product_lo
);

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] m_reg;
    logic [ACC_W-1:0]  acc;
    logic [DATA_W-1:0] q_reg;
    logic              q_m1;

    logic [ACC_W-1:0]  addend_c;
    logic [ACC_W-1:0]  sum_c;
    logic signed [SHR_W-1:0] shifted_c;
    logic              iter_last_c;

    booth_recoder u_recoder (
        .window   ({q_reg[1:0], q_m1}),
        .m        (m_reg),
        .addend_c (addend_c)
    );

    assign sum_c       = acc + addend_c;
    assign shifted_c   = $signed({sum_c, q_reg, q_m1}) >>> 2;
    assign iter_last_c = (cnt == CNT_W'(ITERS));

    // Next-state logic; the RUN cycle after the 16th iteration hands the settled result to DONE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (iter_last_c) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Clear) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            cnt        <= '0;
            m_reg      <= '0;
            acc        <= '0;
            q_reg      <= '0;
            q_m1       <= 1'b0;
            product_hi <= '0;
            product_lo <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next != ST_IDLE);
            done  <= (state_next == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        m_reg <= multiplicand;
                        q_reg <= multiplier;
                        q_m1  <= 1'b0;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    if (!iter_last_c) begin
                        acc   <= shifted_c[SHR_W-1 -: ACC_W];
                        q_reg <= shifted_c[DATA_W:1];
                        q_m1  <= shifted_c[0];
                        cnt   <= cnt + CNT_W'(1);
                    end else begin
                        product_hi <= acc[DATA_W-1:0];
                        product_lo <= q_reg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed vector bench for booth_mult_seq: table of products plus abort/retrigger/back-to-back sequences.
module tb_booth_mult_seq;

    logic        clk;
    logic        Clear;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] product_hi;
    logic [31:0] product_lo;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] prod;
        string       name;
    } vec_t;

    vec_t vecs[8];

    booth_mult_seq dut (
        .clk          (clk),
        .Clear        (Clear),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product_hi   (product_hi),
        .product_lo   (product_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full operation from a start pulse; checks latency, result, pulse width and busy release.
    task automatic mult(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string name);
        int lat;
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        step();
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        check({name, " busy_c0"}, 64'(busy), 64'd1);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (done) begin
                lat = i;
                break;
            end
        end
        check({name, " latency"}, 64'(lat), 64'd17);
        check({name, " product"}, {product_hi, product_lo}, exp);
        check({name, " busy_done"}, 64'(busy), 64'd1);
        step();
        check({name, " done_pulse"}, 64'(done), 64'd0);
        check({name, " busy_idle"}, 64'(busy), 64'd0);
        check({name, " hold"}, {product_hi, product_lo}, exp);
    endtask

    initial begin
        int n_done;
        int lat;
        int lat2;
        logic busy18;

        vecs[0] = '{32'd30,        32'd25,        64'h00000000_000002EE, "30x25"};
        vecs[1] = '{32'hFFFFFFFF,  32'h00000001,  64'hFFFFFFFF_FFFFFFFF, "m1x1"};
        vecs[2] = '{32'h80000000,  32'h80000000,  64'h40000000_00000000, "minxmin"};
        vecs[3] = '{32'h7FFFFFFF,  32'h7FFFFFFF,  64'h3FFFFFFF_00000001, "maxxmax"};
        vecs[4] = '{32'hFFFFFFFD,  32'd7,         64'hFFFFFFFF_FFFFFFEB, "m3x7"};
        vecs[5] = '{32'h12345678,  32'd3,         64'h00000000_369D0368, "hexx3"};
        vecs[6] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  64'h00000000_00000001, "m1xm1"};
        vecs[7] = '{32'h00000000,  32'hDEADBEEF,  64'h00000000_00000000, "zero"};

        Clear        = 1'b1;
        start        = 1'b1;
        multiplicand = 32'd0;
        multiplier   = 32'd0;
        step();
        step();
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst product", {product_hi, product_lo}, 64'd0);

        // First start goes in on the very first edge with Clear low.
        Clear = 1'b0;
        for (int k = 0; k < 8; k++)
            mult(vecs[k].a, vecs[k].b, vecs[k].prod, vecs[k].name);

        // Abort mid-operation with Clear.
        multiplicand = 32'h12345678;
        multiplier   = 32'd3;
        start        = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i < 8; i++) step();
        check("abort hold_prev", {product_hi, product_lo}, vecs[7].prod);
        check("abort busy_pre", 64'(busy), 64'd1);
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort product", {product_hi, product_lo}, 64'd0);
        n_done = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (done) n_done++;
        end
        check("abort no_done", 64'(n_done), 64'd0);
        mult(32'd5, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFEC, "5xm4");

        // Retrigger while busy must be ignored.
        multiplicand = 32'd7;
        multiplier   = 32'd6;
        start        = 1'b1;
        step();
        start = 1'b0;
        n_done = 0;
        lat    = 0;
        busy18 = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            if (i == 5) begin
                start        = 1'b1;
                multiplicand = 32'd9;
                multiplier   = 32'd9;
            end
            step();
            if (i == 5) start = 1'b0;
            if (done) begin
                n_done++;
                if (lat == 0) lat = i;
            end
            if (i == 18) busy18 = busy;
        end
        check("retrig n_done", 64'(n_done), 64'd1);
        check("retrig latency", 64'(lat), 64'd17);
        check("retrig product", {product_hi, product_lo}, 64'h00000000_0000002A);
        check("retrig busy18", 64'(busy18), 64'd0);

        // Start held high: back-to-back operations.
        multiplicand = 32'd2;
        multiplier   = 32'd3;
        start        = 1'b1;
        step();
        multiplicand = 32'd4;
        multiplier   = 32'hFFFFFFFB;
        lat  = 0;
        lat2 = 0;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (done && lat == 0) begin
                lat = i;
                check("b2b first product", {product_hi, product_lo}, 64'h00000000_00000006);
            end else if (done && lat2 == 0) begin
                lat2 = i;
                break;
            end
        end
        start = 1'b0;
        check("b2b first latency", 64'(lat), 64'd17);
        check("b2b second latency", 64'(lat2), 64'd36);
        check("b2b second product", {product_hi, product_lo}, 64'hFFFFFFFF_FFFFFFEC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
